ahb_img_slave: RTL
==================

// Module: ahb_img_slave
// PURPOSE
//  AHB slave image memory: the responder end of the DMA master's AHB bus. Holds
//  source/rotated pixel words in a word-wide SRAM array, serves the master's single
//  and INCR/WRAP burst reads/writes, inserts programmable wait states, and returns
//  a two-cycle ERROR for out-of-range or misaligned transfers. Sits on the bus
//  opposite the DMA's AHB interface; also used as the memory model in the rotate TB.
// PARAMETERS
//  BASE_ADDR    32'h0000_0000  byte base address of the array
//  DEPTH        256            number of 32-bit words (power of 2)
//  AW           8              word index width, log2(DEPTH)
//  WAIT_STATES  1              wait cycles (0..7) inserted on every NONSEQ transfer
// PORTS
//  I_SLV_HCLK    in   1   bus clock, all logic on rising edge
//  I_SLV_HRESET  in   1   asynchronous active-high reset
//  I_SLV_HSEL    in   1   slave select
//  I_SLV_HADDR   in   32  byte address (address phase)
//  I_SLV_HTRANS  in   2   00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
//  I_SLV_HWRITE  in   1   1 write, 0 read
//  I_SLV_HSIZE   in   3   000 byte, 001 half, 010 word; others -> ERROR
//  I_SLV_HBURST  in   3   burst type; informational only, address comes from HADDR
//  I_SLV_HWDATA  in   32  write data (data phase), little-endian lanes
//  O_SLV_HRDATA  out  32  read data, valid when HREADY=1 in a read data phase
//  O_SLV_HREADY  out  1   transfer done / address phase may advance
//  O_SLV_HRESP   out  2   00 OKAY, 01 ERROR (RETRY/SPLIT never issued)
// BEHAVIOUR
//  Reset (async, any time, incl. mid-burst): state=IDLE, HREADY=1, HRESP=00,
//   HRDATA=0, wait counter=0, pending write dropped; SRAM contents NOT cleared.
//  Address phase accepted at a rising edge where HSEL=1, HREADY=1, HTRANS[1]=1;
//   HADDR/HWRITE/HSIZE registered. IDLE/BUSY or HSEL=0: no access, next data
//   phase is zero-wait OKAY.
//  Legality check at acceptance: word index = (HADDR-BASE_ADDR)>>2 must be < DEPTH;
//   HSIZE<=010; half needs HADDR[0]=0, word needs HADDR[1:0]=00. Fail -> ERROR.
//  FSM: IDLE -> WAIT (NONSEQ, legal, WAIT_STATES>0) | DATA (SEQ or WAIT_STATES=0)
//   | ERR1 (illegal). WAIT: HREADY=0, HRESP=00, counts WAIT_STATES cycles -> DATA.
//   DATA: HREADY=1, HRESP=00; next transfer accepted same edge (pipelined).
//   ERR1: HREADY=0, HRESP=01 -> ERR2: HREADY=1, HRESP=01 -> IDLE/next transfer.
//  Read latency: NONSEQ completes WAIT_STATES+1 cycles after address accept; SEQ 1.
//  Write: HWDATA sampled at the edge ending the data phase (HREADY=1); only lanes
//   of HSIZE/HADDR[1:0] updated (byte lane n = addr[1:0]; half lanes 0-1 or 2-3).
//  Read: full word returned regardless of HSIZE; master selects lanes.
//  Read word latched at end of its address phase; if a write to the same word
//   completes on that same edge, written lanes are forwarded (byte-merged) so
//   back-to-back write-then-read returns new data.
//  ERROR transfers never modify SRAM; HRDATA held at previous value.
//  Master changing HTRANS to IDLE during ERR1 is legal; slave still completes ERR2.
//  HRDATA holds last read value outside read data phases.
// TESTING
//  Reset, idle bus -> HREADY=1, HRESP=00, HRDATA=0 every cycle.
//  WAIT_STATES=1: NONSEQ write word 0x04=32'hDEADBEEF, then NONSEQ read 0x04 ->
//   write data phase 2 cycles, read returns 32'hDEADBEEF with HREADY low 1 cycle.
//  INCR4 write 0x10..0x1C then INCR4 read -> NONSEQ 1 wait, 3 SEQ zero-wait, data match.
//  Byte write 8'hAA to 0x21 over word 32'h11223344 -> read 0x20 = 32'h1122AA44.
//  Read addr BASE+4*DEPTH, and half write to 0x01 -> HRESP=01 two cycles, HREADY 0
//   then 1, SRAM unchanged.
//  HRESET pulsed during WAIT of a burst write -> HREADY=1/HRESP=00 immediately,
//   target word unmodified, next NONSEQ served normally.

Source files
------------

// File: rtl/ahb_img_slave.sv
// AHB slave image memory: word-wide SRAM serving single and burst transfers,
// with programmable wait states on NONSEQ and a two-cycle ERROR response.
module ahb_img_slave #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned AW          = 8,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        I_SLV_HCLK,
    input  logic        I_SLV_HRESET,
    input  logic        I_SLV_HSEL,
    input  logic [31:0] I_SLV_HADDR,
    input  logic [1:0]  I_SLV_HTRANS,
    input  logic        I_SLV_HWRITE,
    input  logic [2:0]  I_SLV_HSIZE,
    input  logic [2:0]  I_SLV_HBURST,
    input  logic [31:0] I_SLV_HWDATA,
    output logic [31:0] O_SLV_HRDATA,
    output logic        O_SLV_HREADY,
    output logic [1:0]  O_SLV_HRESP
);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DATA, S_ERR1, S_ERR2} state_t;

    localparam logic [2:0] WS_LOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

    state_t          r_state, w_next;
    logic [2:0]      r_wcnt, w_wcnt_nxt;
    logic [AW-1:0]   r_idx;
    logic [3:0]      r_be;
    logic            r_write;
    logic [31:0]     r_rbuf;
    logic [31:0]     r_hold;
    logic [31:0]     r_mem [DEPTH];

    logic [31:0]     w_offset;
    logic [AW-1:0]   w_idx;
    logic [3:0]      w_be;
    logic            w_size_ok;
    logic            w_legal;
    logic            w_accept;
    logic            w_wr_en;
    logic [31:0]     w_rd_word;
    logic            w_unused;

    assign w_unused     = ^I_SLV_HBURST;
    assign O_SLV_HREADY = !(r_state == S_WAIT || r_state == S_ERR1);
    assign O_SLV_HRESP  = (r_state == S_ERR1 || r_state == S_ERR2) ? 2'b01 : 2'b00;
    assign O_SLV_HRDATA = (r_state == S_DATA && !r_write) ? r_rbuf : r_hold;

    assign w_offset = I_SLV_HADDR - BASE_ADDR;
    assign w_idx    = w_offset[AW+1:2];
    assign w_accept = I_SLV_HSEL && O_SLV_HREADY && I_SLV_HTRANS[1];
    assign w_legal  = (w_offset[31:AW+2] == '0) && w_size_ok;
    assign w_wr_en  = (r_state == S_DATA) && r_write;

    always_comb begin
        w_size_ok = 1'b0;
        w_be      = 4'b1111;
        case (I_SLV_HSIZE)
            3'b000: begin
                w_size_ok = 1'b1;
                w_be      = 4'b0001 << w_offset[1:0];
            end
            3'b001: begin
                w_size_ok = !w_offset[0];
                w_be      = w_offset[1] ? 4'b1100 : 4'b0011;
            end
            3'b010: begin
                w_size_ok = (w_offset[1:0] == 2'b00);
                w_be      = 4'b1111;
            end
            default: w_size_ok = 1'b0;
        endcase
    end

    // A write finishing on the edge that accepts a read of the same word is merged in here.
    always_comb begin
        w_rd_word = r_mem[w_idx];
        if (w_wr_en && (r_idx == w_idx)) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (r_be[b]) w_rd_word[8*b +: 8] = I_SLV_HWDATA[8*b +: 8];
            end
        end
    end

    always_comb begin
        w_next     = r_state;
        w_wcnt_nxt = r_wcnt;
        case (r_state)
            S_WAIT: begin
                if (r_wcnt == 3'd0) w_next = S_DATA;
                else                w_wcnt_nxt = r_wcnt - 3'd1;
            end
            S_ERR1:  w_next = S_ERR2;
            default: w_next = S_IDLE;
        endcase
        if (w_accept) begin
            if (!w_legal) begin
                w_next = S_ERR1;
            end else if (!I_SLV_HTRANS[0] && (WAIT_STATES != 0)) begin
                w_next     = S_WAIT;
                w_wcnt_nxt = WS_LOAD;
            end else begin
                w_next = S_DATA;
            end
        end
    end

    always_ff @(posedge I_SLV_HCLK or posedge I_SLV_HRESET) begin
        if (I_SLV_HRESET) begin
            r_state <= S_IDLE;
            r_wcnt  <= '0;
            r_idx   <= '0;
            r_be    <= '0;
            r_write <= 1'b0;
            r_rbuf  <= '0;
            r_hold  <= '0;
        end else begin
            r_state <= w_next;
            r_wcnt  <= w_wcnt_nxt;
            if (r_state == S_DATA && !r_write) r_hold <= r_rbuf;
            if (w_accept) begin
                r_idx   <= w_idx;
                r_be    <= w_be;
                r_write <= I_SLV_HWRITE;
                if (w_legal && !I_SLV_HWRITE) r_rbuf <= w_rd_word;
            end
        end
    end

    // SRAM contents survive reset; reset only cancels the write by leaving DATA.
    always_ff @(posedge I_SLV_HCLK) begin
        if (w_wr_en) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (r_be[b]) r_mem[r_idx][8*b +: 8] <= I_SLV_HWDATA[8*b +: 8];
            end
        end
    end

endmodule
